fsm_ab_sequencer: RTL

//  Parametrised operand display sequencer: on start, latches operands A/B and mode, shows {A,B}
//  for SHOW_CYC cycles, then shows A-B or the Gray code of {A,B} for RES_CYC cycles, returns idle.

---
 rtl/fsm_ab_sequencer.sv | 89 ++++++++
 1 files changed

// File: rtl/fsm_ab_sequencer.sv
// fsm_ab_sequencer: latches A/B/mode on start, shows {A,B} then A-B or Gray({A,B}) for fixed dwell times.
// Optional FSM_ABORT_EN adds an abort input that cancels a run without a done pulse.
module fsm_ab_sequencer #(
    parameter int W        = 4,
    parameter int SHOW_CYC = 6,
    parameter int RES_CYC  = 3,
    parameter int CNT_W    = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [1:0]     mode,
`ifdef FSM_ABORT_EN
    input  logic           abort,
`endif
    output logic [2*W-1:0] ab_result,
    output logic [1:0]     state,
    output logic           busy,
    output logic           done
);
    typedef enum logic [1:0] {IDLE = 2'b00, SHOW = 2'b01, DIFF = 2'b10, GRAY = 2'b11} state_t;

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] RES_LAST  = CNT_W'(RES_CYC - 1);

    state_t         st;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]   a_q, b_q;
    logic [1:0]     mode_q;
    logic [W-1:0]   diff;
    logic [2*W-1:0] ab;

    always_ff @(posedge clock) begin
        if (reset) begin
            st     <= IDLE;
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: if (start) begin
                    a_q    <= a;
                    b_q    <= b;
                    mode_q <= mode;
                    cnt    <= '0;
                    st     <= SHOW;
                end
                SHOW: if (cnt == SHOW_LAST) begin
                    cnt <= '0;
                    // auto modes pick DIFF only for a strictly larger A
                    st  <= (mode_q == 2'b01 || (mode_q != 2'b10 && a_q > b_q)) ? DIFF : GRAY;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DIFF, GRAY: if (cnt == RES_LAST) begin
                    cnt  <= '0;
                    st   <= IDLE;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            endcase
`ifdef FSM_ABORT_EN
            if (abort && st != IDLE) begin
                st   <= IDLE;
                cnt  <= '0;
                done <= 1'b0;
            end
`endif
        end
    end

    assign ab    = {a_q, b_q};
    assign diff  = a_q - b_q;
    assign state = st;
    assign busy  = st != IDLE;

    always_comb begin
        ab_result = st == IDLE ? {2*W{1'b1}} :
                    st == SHOW ? ab :
                    st == DIFF ? {{W{diff[W-1]}}, diff} :
                                 ab ^ (ab >> 1);
    end
endmodule
